fsmseq_tx: RTL
==============

Name: fsmseq_tx

Overview:
- Serial frame transmitter; the sending end of the 1101-preamble serial link.
- Accepts a parallel payload through a valid/ready handshake.
- Drives the single-bit line: preamble 1101, then the payload MSB first, then holds the line low.
- Waits for a receiver acknowledge, with timeout and bounded automatic retransmission.

Parameters:
- PAYLOAD_W, 4, payload width in bits (1..16).
- ACK_TIMEOUT, 8, number of WAIT_ACK cycles allowed before a timeout (1..255).
- MAX_RETRY, 2, retransmissions after the first attempt before declaring an error (0..7).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  payload offered.
- in_ready  out  1  transmitter can accept a payload.
- in_data  in  PAYLOAD_W  payload; sampled only on an accepting edge.
- ack  in  1  receiver acknowledge; meaningful only in WAIT_ACK.
- data_out  out  1  serial line, registered.
- busy  out  1  frame in progress (any state other than IDLE).
- done  out  1  one-cycle pulse: frame acknowledged.
- err  out  1  one-cycle pulse: retries exhausted.

Behaviour:
Reset and interface rules
- Reset and clock: reset is synchronous, active-high; clock is clk.
- Reset state: state IDLE, data_out=0, done=0, err=0, busy=0, in_ready=1, and all counters and the payload register cleared.
- Reset mid-frame: takes effect at the next edge and aborts the frame; the line returns to 0 immediately.
- in_ready: combinational, equal to (state==IDLE).
- Accept condition: in_valid & in_ready at an edge. That edge latches in_data, clears the retry count and enters PRE.
- in_data changes after acceptance have no effect on the frame.

State machine
- IDLE: data_out=0. Leaves only on acceptance.
- PRE: four cycles. data_out = 1, 1, 0, 1, starting the cycle after the accepting edge, so latency is 1 cycle. Then goes to PAY.
- PAY: PAYLOAD_W cycles. data_out = payload[PAYLOAD_W-1] down to payload[0]. Then goes to WAIT_ACK.
- WAIT_ACK: data_out=0. A wait counter counts cycles from 1 to ACK_TIMEOUT.
  - ack sampled high at any WAIT_ACK edge: next state IDLE, done=1 for exactly the following cycle.
  - Wait counter reaches ACK_TIMEOUT without ack, and retries < MAX_RETRY: retries++, next state PRE, and the same latched payload is retransmitted.
  - Same timeout with retries == MAX_RETRY: next state IDLE, err=1 for exactly the following cycle.
  - ack and timeout on the same edge: ack wins (done, no retry, no err).
- ack outside WAIT_ACK: ignored entirely. It does not shorten a frame or pre-arm WAIT_ACK.

Timing and output rules
- Frame length on the line: 4+PAYLOAD_W cycles.
- Gap between attempts: exactly ACK_TIMEOUT zero cycles.
- Total attempts: at most 1+MAX_RETRY.
- Line idle level: 0 in IDLE and WAIT_ACK, so a receiver in its start state cannot see a false preamble.
- done/err and a new acceptance: done and err are registered and asserted in IDLE. A new payload can be accepted on the same cycle that done or err is high.
- Mutual exclusion: done and err are never high together.
- busy: high from the cycle after acceptance through the last WAIT_ACK cycle.
- Widths: bit index counter is ceil(log2(max(4,PAYLOAD_W))) bits; wait counter is 8 bits; retry counter is 3 bits. No counter wraps in legal use.

Test Plan:
- Basic frame (PAYLOAD_W=4, ACK_TIMEOUT=8, MAX_RETRY=2): reset, then in_data=4'b1010 with in_valid for one cycle -> data_out 1,1,0,1,1,0,1,0 starting the next cycle, then 0. Raise ack on the 3rd WAIT_ACK cycle -> done high for exactly one cycle, in_ready=1, busy=0.
- No ack: send 4'b0110 and never ack -> three identical 8-bit frames, each followed by 8 zero cycles, then err pulses once. done is never asserted and busy drops with err.
- Late ack: ack arrives on the 8th WAIT_ACK cycle of the first attempt -> done pulse, no retransmission, err=0.
- Early ack: ack held high throughout PRE and PAY, then dropped before WAIT_ACK -> ack ignored, timeout and retransmission proceed normally.
- Reset mid-frame: assert reset during the 2nd payload bit -> data_out=0 the next cycle, in_ready=1, busy=0, no done or err. A fresh in_data=4'b1111 afterwards transmits 1,1,0,1,1,1,1,1.
- Busy handling: in_valid held high with in_data changing every cycle during a frame -> no acceptance until IDLE, and the transmitted payload equals the value latched at the original accept.

Source files
------------

// File: rtl/fsmseq_tx.sv
// Serial frame transmitter: sends preamble 1101 then the payload MSB first,
// then waits for an acknowledge with timeout and bounded retransmission.
module fsmseq_tx #(
  parameter int unsigned PAYLOAD_W   = 4,
  parameter int unsigned ACK_TIMEOUT = 8,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  input  logic                 ack,
  output logic                 data_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned CW = (PAYLOAD_W > 4) ? $clog2(PAYLOAD_W) : 2;
  localparam logic [3:0] PREAMBLE = 4'b1101;

  typedef enum logic [1:0] {IDLE, PRE, PAY, WAIT_ACK} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [7:0]             wait_q, wait_d;
  logic [2:0]             retry_q, retry_d;
  logic [PAYLOAD_W-1:0]   pay_q, pay_d;
  logic                   dout_q, dout_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [CW-1:0]          pay_idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    retry_d = retry_q;
    pay_d   = pay_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = PRE;
          cnt_d   = '0;
          retry_d = '0;
          pay_d   = in_data;
        end
      end
      PRE: begin
        if (cnt_q == CW'(3)) begin
          state_d = PAY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PAY: begin
        if (cnt_q == CW'(PAYLOAD_W - 1)) begin
          state_d = WAIT_ACK;
          cnt_d   = '0;
          wait_d  = 8'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_ACK: begin
        // ack takes priority over a timeout on the same edge
        if (ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (wait_q == 8'(ACK_TIMEOUT)) begin
          if (retry_q < 3'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = PRE;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The line is registered, so the bit is chosen from the state being entered.
    pay_idx = CW'(PAYLOAD_W - 1) - cnt_d;
    dout_d  = 1'b0;
    unique case (state_d)
      PRE:     dout_d = PREAMBLE[2'd3 - cnt_d[1:0]];
      PAY:     dout_d = pay_d[pay_idx];
      default: dout_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      retry_q <= '0;
      pay_q   <= '0;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      retry_q <= retry_d;
      pay_q   <= pay_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign data_out = dout_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
